// File: rtl/ula_nibble_seq.sv
// Nibble-serial sequencer: runs a W-bit operation through one shared 4-bit
// 74181-style ALU slice, LSB nibble first, and returns the result over valid/ready.
module ula_nibble_seq #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [3:0]   op_s,
    input  logic         op_m,
    input  logic         op_cin,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_cin,
    input  logic [3:0]   alu_f,
    input  logic         alu_cout,
    input  logic         alu_eq,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_f,
    output logic         res_cout,
    output logic         res_zero,
    output logic         res_eq
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [3:0]         s_reg;
    logic               m_reg;
    logic               cin_reg;
    logic               carry;
    logic               eq_acc;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       f_acc;
    logic               accept;
    logic               running;
    logic               done;

    assign start_ready = (state == IDLE);
    assign accept      = start_ready && start_valid;
    assign running     = (state == RUN);
    assign done        = (state == DONE);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is assigned before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid)       state_nxt = RUN;
            RUN:     if (idx == LAST_IDX)   state_nxt = DONE;
            DONE:    if (res_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Operands are captured only on the accept edge; the running carry ripples
    // alu_cout in arithmetic mode and re-injects the latched cin in logic mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            s_reg   <= '0;
            m_reg   <= 1'b0;
            cin_reg <= 1'b0;
            carry   <= 1'b0;
            eq_acc  <= 1'b0;
            idx     <= '0;
            f_acc   <= '0;
        end else if (accept) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            s_reg   <= op_s;
            m_reg   <= op_m;
            cin_reg <= op_cin;
            carry   <= op_cin;
            eq_acc  <= 1'b1;
            idx     <= '0;
            f_acc   <= '0;
        end else if (running) begin
            f_acc[4*idx +: 4] <= alu_f;
            eq_acc            <= eq_acc & alu_eq;
            carry             <= m_reg ? cin_reg : alu_cout;
            idx               <= idx + 1'b1;
        end
    end

    // ALU inputs come straight from registers and are parked at zero outside RUN.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = '0;
        alu_m   = 1'b0;
        alu_cin = 1'b0;
        if (running) begin
            alu_a   = a_reg[4*idx +: 4];
            alu_b   = b_reg[4*idx +: 4];
            alu_s   = s_reg;
            alu_m   = m_reg;
            alu_cin = carry;
        end
    end

    assign res_valid = done;
    assign res_f     = f_acc;
    assign res_cout  = done & ~m_reg & carry;
    assign res_zero  = done & (f_acc == '0);
    assign res_eq    = done & eq_acc;

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Directed bench for ula_nibble_seq (NIBBLES=4) driving a small behavioural
// 74181-style slice model for the functions exercised here.
module tb_ula_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin;
    logic [3:0]   alu_f;
    logic         alu_cout;
    logic         alu_eq;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cout;
    logic         res_zero;
    logic         res_eq;

    int n_cmp;
    int n_err;
    int latency;
    logic [3:0] cin_hist;

    ula_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_s        (op_s),
        .op_m        (op_m),
        .op_cin      (op_cin),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_m       (alu_m),
        .alu_cin     (alu_cin),
        .alu_f       (alu_f),
        .alu_cout    (alu_cout),
        .alu_eq      (alu_eq),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_f       (res_f),
        .res_cout    (res_cout),
        .res_zero    (res_zero),
        .res_eq      (res_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: arithmetic S=0001 is A+B+cin, S=0110 is A+~B+cin (A-B when
    // cin=1); logic S=0110 is XOR, S=1111 passes A. a_eq_b flags A==B.
    logic [4:0] sum5;
    always_comb begin
        sum5     = '0;
        alu_f    = alu_a;
        alu_cout = 1'b0;
        alu_eq   = (alu_a == alu_b);
        if (!alu_m) begin
            case (alu_s)
                4'b0001: sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                4'b0110: sum5 = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
                default: sum5 = {1'b0, alu_a};
            endcase
            alu_f    = sum5[3:0];
            alu_cout = sum5[4];
        end else begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1111: alu_f = alu_a;
                default: alu_f = alu_a;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, then count cycles to res_valid while recording alu_cin
    // per RUN cycle (bit i = nibble i).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cin);
        op_a        = a;
        op_b        = b;
        op_s        = s;
        op_m        = m;
        op_cin      = cin;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        latency     = 0;
        cin_hist    = '0;
        while (!res_valid && latency < 20) begin
            if (latency < 4) cin_hist[latency] = alu_cin;
            step();
            latency++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        op_s        = '0;
        op_m        = 1'b0;
        op_cin      = 1'b0;

        // Reset state
        step();
        step();
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_res_valid",   32'(res_valid),   32'd0);
        check("rst_res_f",       32'(res_f),       32'd0);
        check("rst_flags",       32'({res_cout, res_zero, res_eq}), 32'd0);
        check("rst_alu",         32'({alu_a, alu_b, alu_s, alu_m, alu_cin}), 32'd0);
        #2 rst = 1'b0;

        // Add
        run_op(16'h1234, 16'h0FFF, 4'b0001, 1'b0, 1'b0);
        check("add_latency",     32'(latency),     32'd4);
        check("add_res_f",       32'(res_f),       32'h2233);
        check("add_res_cout",    32'(res_cout),    32'd0);
        check("add_res_zero",    32'(res_zero),    32'd0);
        check("add_res_eq",      32'(res_eq),      32'd0);
        check("add_start_ready", 32'(start_ready), 32'd0);
        release_result();
        check("add_idle_ready",  32'(start_ready), 32'd1);

        // Carry out and zero
        run_op(16'hFFFF, 16'h0001, 4'b0001, 1'b0, 1'b0);
        check("cz_latency",  32'(latency),  32'd4);
        check("cz_res_f",    32'(res_f),    32'h0000);
        check("cz_res_cout", 32'(res_cout), 32'd1);
        check("cz_res_zero", 32'(res_zero), 32'd1);
        release_result();

        // Subtract with carry-in chain
        run_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1);
        check("sub_latency",  32'(latency),  32'd4);
        check("sub_cin_seq",  32'(cin_hist), 32'b0001);
        check("sub_res_f",    32'(res_f),    32'h4FFF);
        check("sub_res_cout", 32'(res_cout), 32'd1);
        release_result();

        // Logic XOR, unequal operands
        run_op(16'hA5A5, 16'h5A5A, 4'b0110, 1'b1, 1'b0);
        check("xor_res_f",    32'(res_f),    32'hFFFF);
        check("xor_res_cout", 32'(res_cout), 32'd0);
        check("xor_res_eq",   32'(res_eq),   32'd0);
        release_result();

        // Logic pass-A, equal operands; cin=1 must not leak into res_cout
        run_op(16'h1234, 16'h1234, 4'b1111, 1'b1, 1'b1);
        check("pass_res_f",    32'(res_f),    32'h1234);
        check("pass_res_eq",   32'(res_eq),   32'd1);
        check("pass_res_cout", 32'(res_cout), 32'd0);

        // Backpressure in DONE with start_valid pulsing
        op_a   = 16'h0F0F;
        op_b   = 16'h0101;
        op_s   = 4'b0001;
        op_m   = 1'b0;
        op_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start_valid = ~start_valid;
            step();
            check("bp_res_valid",   32'(res_valid),   32'd1);
            check("bp_res_f",       32'(res_f),       32'h1234);
            check("bp_res_cout",    32'(res_cout),    32'd0);
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        release_result();
        check("bp_idle_ready", 32'(start_ready), 32'd1);
        check("bp_idle_valid", 32'(res_valid),   32'd0);
        check("bp_res_f_held", 32'(res_f),       32'h1234);

        // Reset during the second RUN cycle
        op_a        = 16'h1111;
        op_b        = 16'h2222;
        op_s        = 4'b0001;
        op_m        = 1'b0;
        op_cin      = 1'b1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        check("mid_alu_a_live", 32'(alu_a), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_alu",         32'({alu_a, alu_b, alu_s, alu_m, alu_cin}), 32'd0);
        check("mid_rst_start_ready", 32'(start_ready), 32'd1);
        check("mid_rst_res_valid",   32'(res_valid),   32'd0);
        check("mid_rst_res_f",       32'(res_f),       32'd0);
        check("mid_rst_flags",       32'({res_cout, res_zero, res_eq}), 32'd0);
        step();
        #2 rst = 1'b0;

        run_op(16'h0001, 16'h0001, 4'b0001, 1'b0, 1'b0);
        check("post_latency",  32'(latency),  32'd4);
        check("post_res_f",    32'(res_f),    32'h0002);
        check("post_res_cout", 32'(res_cout), 32'd0);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
